hazard_stall_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage ARM-subset CPU; sits beside the forwarding unit.
- Handles the hazards that forwarding cannot resolve: load-use stalls, taken-branch flushes and data-memory wait states.
- Drives the write-enables of the PC and pipeline registers, plus bubble and flush controls.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

---
 rtl/hazard_stall_controller_if.sv | 37 +++
 rtl/hazard_stall_controller.sv | 131 +++++++++++++
 tb/tb_hazard_stall_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
// Hazard/stall controller bus: hazard-detection inputs from ID/EX and the
// pipeline enable, bubble and flush controls returned to the datapath.
interface hazard_stall_controller_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       IFID_Rn;
   logic [4:0]       IFID_Rm;
   logic             IFID_UsesRm;
   logic             IDEX_MemRead;
   logic [4:0]       IDEX_Rd;
   logic             branch_taken;
   logic             mem_busy;
   logic             PC_Write;
   logic             IFID_Write;
   logic             IDEX_Write;
   logic             EXMEM_Write;
   logic             MEMWB_Write;
   logic             IDEX_Bubble;
   logic             IFID_Flush;
   logic [CNT_W-1:0] stall_count;
   logic             mem_timeout;

   // The pipeline datapath is the master; the controller is the slave.
   modport master (
      output IFID_Rn, IFID_Rm, IFID_UsesRm, IDEX_MemRead, IDEX_Rd,
             branch_taken, mem_busy,
      input  PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
             IDEX_Bubble, IFID_Flush, stall_count, mem_timeout
   );

   modport slave (
      input  IFID_Rn, IFID_Rm, IFID_UsesRm, IDEX_MemRead, IDEX_Rd,
             branch_taken, mem_busy,
      output PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
             IDEX_Bubble, IFID_Flush, stall_count, mem_timeout
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// data-memory wait states, with a saturating stall counter and timeout flag.
module hazard_stall_controller #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16,
   parameter int MEM_TIMEOUT  = 255
) (
   input logic                     clk,
   input logic                     reset,
   hazard_stall_controller_if.slave bus
);

   typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} ctrlState_t;

   localparam logic [2:0] FLUSH_RELOAD  = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);
   localparam ctrlState_t BRANCH_STATE  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

   ctrlState_t       state_q, state_d;
   logic [2:0]       flushCnt_q, flushCnt_d;
   logic [7:0]       waitCnt_q, waitCnt_d;
   logic             pendingFlush_q, pendingFlush_d;
   logic             memTimeout_q, memTimeout_d;
   logic [CNT_W-1:0] stallCount_q, stallCount_d;

   logic loadUse;
   logic branchNow;
   logic flushing;
   logic pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite;
   logic idexBubble, ifidFlush;

   // Register 31 is the zero register, so a load targeting it never creates a hazard.
   assign loadUse = bus.IDEX_MemRead && (bus.IDEX_Rd != 5'd31) &&
                    ((bus.IDEX_Rd == bus.IFID_Rn) ||
                     (bus.IFID_UsesRm && (bus.IDEX_Rd == bus.IFID_Rm)));

   assign branchNow = bus.branch_taken || ((state_q == MEM_WAIT) && pendingFlush_q);
   assign flushing  = (state_q == FLUSH) || ((state_q == MEM_WAIT) && (flushCnt_q != 3'd0));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= RUN;
         flushCnt_q     <= 3'd0;
         waitCnt_q      <= 8'd0;
         pendingFlush_q <= 1'b0;
         memTimeout_q   <= 1'b0;
         stallCount_q   <= '0;
      end else begin
         state_q        <= state_d;
         flushCnt_q     <= flushCnt_d;
         waitCnt_q      <= waitCnt_d;
         pendingFlush_q <= pendingFlush_d;
         memTimeout_q   <= memTimeout_d;
         stallCount_q   <= stallCount_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      flushCnt_d     = flushCnt_q;
      waitCnt_d      = waitCnt_q;
      pendingFlush_d = pendingFlush_q;
      memTimeout_d   = memTimeout_q;
      stallCount_d   = stallCount_q;

      if (bus.mem_busy) begin
         // Flush progress is frozen while memory holds the pipeline.
         state_d        = MEM_WAIT;
         waitCnt_d      = (waitCnt_q == 8'hFF) ? waitCnt_q : waitCnt_q + 8'd1;
         pendingFlush_d = pendingFlush_q || bus.branch_taken;
         memTimeout_d   = memTimeout_q || (waitCnt_d >= TIMEOUT_LIMIT);
      end else begin
         waitCnt_d      = 8'd0;
         pendingFlush_d = 1'b0;
         if (branchNow) begin
            flushCnt_d = FLUSH_RELOAD;
            state_d    = BRANCH_STATE;
         end else if (flushing) begin
            flushCnt_d = flushCnt_q - 3'd1;
            state_d    = (flushCnt_q == 3'd1) ? RUN : FLUSH;
         end else begin
            flushCnt_d = 3'd0;
            state_d    = RUN;
         end
      end

      if (!pcWrite && (stallCount_q != {CNT_W{1'b1}})) begin
         stallCount_d = stallCount_q + CNT_W'(1);
      end
   end

   always_comb begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      idexWrite  = 1'b1;
      exmemWrite = 1'b1;
      memwbWrite = 1'b1;
      idexBubble = 1'b0;
      ifidFlush  = 1'b0;

      if (reset) begin
         pcWrite = 1'b1;
      end else if (bus.mem_busy) begin
         pcWrite    = 1'b0;
         ifidWrite  = 1'b0;
         idexWrite  = 1'b0;
         exmemWrite = 1'b0;
         memwbWrite = 1'b0;
      end else if (flushing) begin
         ifidFlush  = 1'b1;
         idexBubble = 1'b1;
      end else if (branchNow) begin
         ifidFlush = 1'b1;
      end else if (loadUse) begin
         pcWrite    = 1'b0;
         ifidWrite  = 1'b0;
         idexBubble = 1'b1;
      end
   end

   assign bus.PC_Write    = pcWrite;
   assign bus.IFID_Write  = ifidWrite;
   assign bus.IDEX_Write  = idexWrite;
   assign bus.EXMEM_Write = exmemWrite;
   assign bus.MEMWB_Write = memwbWrite;
   assign bus.IDEX_Bubble = idexBubble;
   assign bus.IFID_Flush  = ifidFlush;
   assign bus.stall_count = stallCount_q;
   assign bus.mem_timeout = memTimeout_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed per-cycle vectors push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_hazard_stall_controller;

   localparam int CNT_W = 4;

   // Control word order: {PC, IFID, IDEX, EXMEM, MEMWB, Bubble, Flush}
   localparam logic [6:0] NORM  = 7'b1111100;
   localparam logic [6:0] STALL = 7'b0011110;
   localparam logic [6:0] BRF   = 7'b1111101;
   localparam logic [6:0] FLSH  = 7'b1111111;
   localparam logic [6:0] HOLD  = 7'b0000000;

   typedef struct {
      int               vecId;
      logic [6:0]       ctrl;
      logic [CNT_W-1:0] cnt;
      logic             timeout;
   } expect_t;

   logic    clk;
   logic    reset;
   expect_t sbQ[$];
   int      compared;
   int      mismatched;
   int      vecNum;

   hazard_stall_controller_if #(.CNT_W(CNT_W)) bus ();

   hazard_stall_controller #(
      .FLUSH_CYCLES(3),
      .CNT_W       (CNT_W),
      .MEM_TIMEOUT (3)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one cycle of inputs just after the clock edge and record what it should produce.
   task automatic applyStimulus(input logic rst, input logic busy, input logic br,
                                input logic memRead, input logic [4:0] rd,
                                input logic [4:0] rn, input logic [4:0] rm,
                                input logic usesRm, input logic [6:0] expCtrl,
                                input int expCnt, input logic expTo);
      expect_t e;
      @(posedge clk);
      #1;
      reset            = rst;
      bus.mem_busy     = busy;
      bus.branch_taken = br;
      bus.IDEX_MemRead = memRead;
      bus.IDEX_Rd      = rd;
      bus.IFID_Rn      = rn;
      bus.IFID_Rm      = rm;
      bus.IFID_UsesRm  = usesRm;
      vecNum++;
      e.vecId   = vecNum;
      e.ctrl    = expCtrl;
      e.cnt     = CNT_W'(expCnt);
      e.timeout = expTo;
      sbQ.push_back(e);
   endtask

   task automatic idle(input logic [6:0] expCtrl, input int expCnt, input logic expTo);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, expCtrl, expCnt, expTo);
   endtask

   task automatic busyCycle(input logic br, input int expCnt, input logic expTo);
      applyStimulus(1'b0, 1'b1, br, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, HOLD, expCnt, expTo);
   endtask

   task automatic checkOutput(input expect_t e);
      logic [6:0] gotCtrl;
      gotCtrl = {bus.PC_Write, bus.IFID_Write, bus.IDEX_Write, bus.EXMEM_Write,
                 bus.MEMWB_Write, bus.IDEX_Bubble, bus.IFID_Flush};
      compared++;
      if (gotCtrl !== e.ctrl) begin
         mismatched++;
         $display("[TB] FAIL ctrl vec%0d: got %b want %b", e.vecId, gotCtrl, e.ctrl);
      end
      compared++;
      if (bus.stall_count !== e.cnt) begin
         mismatched++;
         $display("[TB] FAIL stall_count vec%0d: got %0d want %0d", e.vecId, bus.stall_count, e.cnt);
      end
      compared++;
      if (bus.mem_timeout !== e.timeout) begin
         mismatched++;
         $display("[TB] FAIL mem_timeout vec%0d: got %b want %b", e.vecId, bus.mem_timeout, e.timeout);
      end
   endtask

   initial begin
      expect_t e;
      forever begin
         @(negedge clk);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      compared         = 0;
      mismatched       = 0;
      vecNum           = 0;
      reset            = 1'b1;
      bus.mem_busy     = 1'b0;
      bus.branch_taken = 1'b0;
      bus.IDEX_MemRead = 1'b0;
      bus.IDEX_Rd      = 5'd0;
      bus.IFID_Rn      = 5'd0;
      bus.IFID_Rm      = 5'd0;
      bus.IFID_UsesRm  = 1'b0;

      // Reset state, including a load-use pattern held during reset
      applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM, 0, 0);
      applyStimulus(1, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, NORM, 0, 0);

      // Load-use on Rn, then bubble clears MemRead
      applyStimulus(0, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, STALL, 0, 0);
      applyStimulus(0, 0, 0, 0, 5'd0, 5'd2, 5'd0, 0, NORM, 1, 0);

      // X31 never hazards; Rm only counts when used
      applyStimulus(0, 0, 0, 1, 5'd31, 5'd31, 5'd0, 0, NORM, 1, 0);
      applyStimulus(0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, NORM, 1, 0);
      applyStimulus(0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 1, STALL, 1, 0);
      applyStimulus(0, 0, 0, 1, 5'd31, 5'd31, 5'd31, 1, NORM, 2, 0);

      // Branch together with load-use: 3 flush cycles, no stall
      applyStimulus(0, 0, 1, 1, 5'd2, 5'd2, 5'd0, 0, BRF, 2, 0);
      applyStimulus(0, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, FLSH, 2, 0);
      idle(FLSH, 2, 0);
      idle(NORM, 2, 0);

      // Branch inside FLUSH reloads the countdown
      applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, BRF, 2, 0);
      idle(FLSH, 2, 0);
      applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, FLSH, 2, 0);
      idle(FLSH, 2, 0);
      idle(FLSH, 2, 0);
      idle(NORM, 2, 0);

      // mem_busy x4 with a branch in cycle 2 becomes a pending flush
      busyCycle(0, 2, 0);
      busyCycle(1, 3, 0);
      busyCycle(0, 4, 0);
      busyCycle(0, 5, 1);
      idle(BRF, 6, 1);
      idle(FLSH, 6, 1);
      idle(FLSH, 6, 1);
      idle(NORM, 6, 1);

      // Reset clears the sticky timeout and the counter
      applyStimulus(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM, 6, 1);
      idle(NORM, 0, 0);

      // Short busy bursts: wait count must clear between them
      busyCycle(0, 0, 0);
      busyCycle(0, 1, 0);
      idle(NORM, 2, 0);
      busyCycle(0, 2, 0);
      idle(NORM, 3, 0);

      // Five busy cycles: timeout rises after the third and stays
      busyCycle(0, 3, 0);
      busyCycle(0, 4, 0);
      busyCycle(0, 5, 0);
      busyCycle(0, 6, 1);
      busyCycle(0, 7, 1);
      idle(NORM, 8, 1);
      idle(NORM, 8, 1);

      // Flush interrupted by mem_busy resumes its countdown afterwards
      applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, BRF, 8, 1);
      busyCycle(0, 8, 1);
      idle(FLSH, 9, 1);
      idle(FLSH, 9, 1);
      idle(NORM, 9, 1);

      // Reset mid-FLUSH with mem_busy high wins
      applyStimulus(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, BRF, 9, 1);
      applyStimulus(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, NORM, 9, 1);
      idle(NORM, 0, 0);

      // Twenty stall cycles saturate the 4-bit counter at 15
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, STALL, (i > 15) ? 15 : i, 0);
      end
      idle(NORM, 15, 0);

      for (int k = 0; k < 10 && sbQ.size() != 0; k++) begin
         @(posedge clk);
      end
      if (sbQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL drain: got %0d pending want 0", sbQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
